// File: rtl/riscv_blk_wb_pkg.sv
// ----------------------------------------------------------------------------
// riscv_blk_wb_pkg
// Shared types and helpers for the block write-back engine.
//   blk_wb_state_e : engine state (IDLE, WRITE, DONE, ERR)
//   bswap_word     : reverse the byte order of the low nbytes of a word
//   is_aligned     : true when addr is aligned to a wb-byte boundary
// The helpers work on a maximum-width container so they can serve any
// WORD_W / ADDR_W instantiation. Callers zero-extend in and truncate out.
// ----------------------------------------------------------------------------
package riscv_blk_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } blk_wb_state_e;

    localparam int unsigned MAX_WORD_W = 512;
    localparam int unsigned MAX_ADDR_W = 64;

    // Byte b of the result takes byte (nbytes-1-b) of the input; bytes at or
    // above nbytes are left zero.
    function automatic logic [MAX_WORD_W-1:0] bswap_word(
        input logic [MAX_WORD_W-1:0] w,
        input int unsigned           nbytes
    );
        logic [MAX_WORD_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < MAX_WORD_W / 8; b++) begin
            if (b < nbytes) begin
                r[b*8 +: 8] = w[(nbytes-1-b)*8 +: 8];
            end
        end
        return r;
    endfunction

    // Checks the low ceil(log2(wb)) address bits; wb = 1 is always aligned.
    function automatic logic is_aligned(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           wb
    );
        logic [MAX_ADDR_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
            if ((64'd1 << i) < 64'(wb)) begin
                mask[i] = 1'b1;
            end
        end
        return (addr & mask) == '0;
    endfunction

endpackage

// File: rtl/riscv_blk_wb_sel.sv
// ----------------------------------------------------------------------------
// riscv_blk_wb_sel
// Combinational word select plus optional byte swap.
//   blk_i  [BLK_W]  : block snapshot, word k = blk_i[k*WORD_W +: WORD_W]
//   k_i    [CNT_W]  : word index to select
//   swap_i          : reverse byte order within the selected word
//   word_o [WORD_W] : selected (and possibly swapped) word
// ----------------------------------------------------------------------------
module riscv_blk_wb_sel
    import riscv_blk_wb_pkg::*;
#(
    parameter int unsigned BLK_W  = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 2
) (
    input  logic [BLK_W-1:0]  blk_i,
    input  logic [CNT_W-1:0]  k_i,
    input  logic              swap_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] raw_word;
    logic [WORD_W-1:0] swp_word;

    always_comb begin
        raw_word = blk_i[int'(k_i)*WORD_W +: WORD_W];
        swp_word = WORD_W'(bswap_word(MAX_WORD_W'(raw_word), WORD_W / 8));
        word_o   = swap_i ? swp_word : raw_word;
    end

endmodule

// File: rtl/riscv_blk_wb.sv
// ----------------------------------------------------------------------------
// riscv_blk_wb
// Write-back engine: stores a BLK_W-bit result block to memory as NUM_W
// word writes over a req/gnt handshake while holding the core halted.
//   clk, rst_n         : clock, synchronous active-low reset
//   start_i            : start request (honoured only in IDLE)
//   base_addr_i        : byte address of block word 0 (must be WB-aligned)
//   blk_data_i         : result block, captured on start
//   desc_order_i       : 0 = words 0..N-1, 1 = words N-1..0
//   byte_swap_i        : reverse bytes inside every written word
//   busy_o, halt_en_o  : engine active / core halt request
//   done_o, err_o      : completion pulse / misaligned-start pulse
//   mem_req_o, mem_gnt_i, mem_addr_o, mem_wdata_o, mem_be_o : write port
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module riscv_blk_wb
    import riscv_blk_wb_pkg::*;
#(
    parameter int unsigned BLK_W  = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [BLK_W-1:0]      blk_data_i,
    input  logic                  desc_order_i,
    input  logic                  byte_swap_i,
    output logic                  busy_o,
    output logic                  halt_en_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [WORD_W-1:0]     mem_wdata_o,
    output logic [WORD_W/8-1:0]   mem_be_o
);

    localparam int unsigned NUM_W = BLK_W / WORD_W;
    localparam int unsigned WB    = WORD_W / 8;
    localparam int unsigned CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_W - 1);

    blk_wb_state_e     state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              desc_q, desc_d;
    logic              swap_q, swap_d;

    logic              busy_q, busy_d;
    logic              halt_q, halt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WB-1:0]     be_q, be_d;

    logic              last_word;
    logic [WORD_W-1:0] sel_word;

    // Word for the next request is selected from the *next* snapshot/index,
    // so the very first request after start already sees blk_data_i.
    riscv_blk_wb_sel #(
        .BLK_W  (BLK_W),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_sel (
        .blk_i  (blk_d),
        .k_i    (idx_d),
        .swap_i (swap_d),
        .word_o (sel_word)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        blk_d     = blk_q;
        base_d    = base_q;
        desc_d    = desc_q;
        swap_d    = swap_q;
        busy_d    = 1'b0;
        halt_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        req_d     = 1'b0;
        last_word = desc_q ? (idx_q == '0) : (idx_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (is_aligned(MAX_ADDR_W'(base_addr_i), WB)) begin
                        state_d = WRITE;
                        blk_d   = blk_data_i;
                        base_d  = base_addr_i;
                        desc_d  = desc_order_i;
                        swap_d  = byte_swap_i;
                        idx_d   = desc_order_i ? LAST_IDX : '0;
                        busy_d  = 1'b1;
                        halt_d  = 1'b1;
                        req_d   = 1'b1;
                    end else begin
                        state_d = ERR;
                        busy_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                halt_d = 1'b1;
                req_d  = 1'b1;
                if (req_q && mem_gnt_i) begin
                    if (last_word) begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = desc_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Address wraps modulo 2^ADDR_W by construction of the adder width.
        addr_d  = req_d ? (base_d + (ADDR_W'(idx_d) * ADDR_W'(WB))) : '0;
        wdata_d = req_d ? sel_word : '0;
        be_d    = req_d ? '1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            blk_q   <= '0;
            base_q  <= '0;
            desc_q  <= 1'b0;
            swap_q  <= 1'b0;
            busy_q  <= 1'b0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            base_q  <= base_d;
            desc_q  <= desc_d;
            swap_q  <= swap_d;
            busy_q  <= busy_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign busy_o      = busy_q;
    assign halt_en_o   = halt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

endmodule

// File: tb/tb_riscv_blk_wb.sv
module tb_riscv_blk_wb;

    localparam int BLK_W  = 128;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int NUM_W  = 4;
    localparam int WB     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic [ADDR_W-1:0]  base_addr_i = '0;
    logic [BLK_W-1:0]   blk_data_i = '0;
    logic               desc_order_i = 1'b0;
    logic               byte_swap_i = 1'b0;
    logic               busy_o, halt_en_o, done_o, err_o, mem_req_o;
    logic               mem_gnt_i = 1'b1;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [WORD_W-1:0]  mem_wdata_o;
    logic [3:0]         mem_be_o;

    riscv_blk_wb #(.BLK_W(BLK_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .blk_data_i(blk_data_i), .desc_order_i(desc_order_i), .byte_swap_i(byte_swap_i),
        .busy_o(busy_o), .halt_en_o(halt_en_o), .done_o(done_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o)
    );

    // Second instance with a 256-bit block (8 words)
    logic               start2 = 1'b0;
    logic [31:0]        base2 = '0;
    logic [255:0]       blk2 = '0;
    logic               gnt2 = 1'b1;
    logic               busy2, halt2, done2, err2, req2;
    logic [31:0]        addr2, wdata2;
    logic [3:0]         be2;

    riscv_blk_wb #(.BLK_W(256), .WORD_W(32), .ADDR_W(32)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .base_addr_i(base2),
        .blk_data_i(blk2), .desc_order_i(1'b0), .byte_swap_i(1'b0),
        .busy_o(busy2), .halt_en_o(halt2), .done_o(done2), .err_o(err2),
        .mem_req_o(req2), .mem_gnt_i(gnt2), .mem_addr_o(addr2),
        .mem_wdata_o(wdata2), .mem_be_o(be2)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int t0b   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          mph = 0;  // 0 idle, 1 writing, 2 done, 3 error
    logic        e_busy = 0, e_halt = 0, e_done = 0, e_err = 0, e_req = 0;
    logic [31:0] e_addr = 0, e_data = 0;
    wr_t         mw;
    int          mk;

    always @(posedge clk) begin
        if (!rst_n) begin
            mph = 0;
            exp_q.delete();
            e_busy = 0; e_halt = 0; e_done = 0; e_err = 0; e_req = 0;
        end else begin
            e_done = 0;
            e_err  = 0;
            case (mph)
                0: if (start_i) begin
                    if (base_addr_i % WB == 0) begin
                        for (int j = 0; j < NUM_W; j++) begin
                            mk   = desc_order_i ? (NUM_W - 1 - j) : j;
                            mw.a = base_addr_i + 32'(mk * WB);
                            mw.d = blk_data_i[mk*32 +: 32];
                            if (byte_swap_i) mw.d = {<<8{mw.d}};
                            exp_q.push_back(mw);
                        end
                        mph = 1; e_req = 1; e_busy = 1; e_halt = 1;
                    end else begin
                        mph = 3; e_err = 1; e_busy = 1; e_halt = 0; e_req = 0;
                    end
                end
                1: if (e_req && mem_gnt_i) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        mph = 2; e_req = 0; e_done = 1;
                    end
                end
                default: begin
                    mph = 0; e_busy = 0; e_halt = 0; e_req = 0;
                end
            endcase
            if (exp_q.size() > 0) begin
                e_addr = exp_q[0].a;
                e_data = exp_q[0].d;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_o", 64'(busy_o), 64'(e_busy));
            check("halt_en_o", 64'(halt_en_o), 64'(e_halt));
            check("done_o", 64'(done_o), 64'(e_done));
            check("err_o", 64'(err_o), 64'(e_err));
            check("mem_req_o", 64'(mem_req_o), 64'(e_req));
            check("mem_be_o", 64'(mem_be_o), e_req ? 64'hF : 64'h0);
            if (e_req) begin
                check("mem_addr_o", 64'(mem_addr_o), 64'(e_addr));
                check("mem_wdata_o", 64'(mem_wdata_o), 64'(e_data));
            end
        end
    end

    // ---------------- observation logs ----------------
    wr_t log_q[$];
    int  log_c[$];
    int  done_rel = -1, err_rel = -1, req_cnt = 0, halt_cnt = 0, a4_cnt = 0;
    wr_t log2_q[$];
    int  log2_c[$];
    int  done2_rel = -1;

    always @(negedge clk) begin
        if (mem_req_o) begin
            req_cnt++;
            if (mem_addr_o == 32'h1000_0004) a4_cnt++;
        end
        if (halt_en_o) halt_cnt++;
        if (mem_req_o && mem_gnt_i) begin
            log_q.push_back({mem_addr_o, mem_wdata_o});
            log_c.push_back(cyc - t0);
        end
        if (done_o) done_rel = cyc - t0;
        if (err_o) err_rel = cyc - t0;
        if (req2 && gnt2) begin
            log2_q.push_back({addr2, wdata2});
            log2_c.push_back(cyc - t0b);
        end
        if (done2) done2_rel = cyc - t0b;
    end

    task automatic clear_log();
        log_q.delete(); log_c.delete();
        done_rel = -1; err_rel = -1; req_cnt = 0; halt_cnt = 0; a4_cnt = 0;
    endtask

    // ---------------- grant driver ----------------
    int gmode = 0;  // 0 tied high, 1 random, 2 low in window [glo,ghi]
    int glo = 0, ghi = -1;
    always @(posedge clk) begin
        #2;
        case (gmode)
            1:       mem_gnt_i = ($urandom % 4) != 0;
            2:       mem_gnt_i = !(((cyc - t0) >= glo) && ((cyc - t0) <= ghi));
            default: mem_gnt_i = 1'b1;
        endcase
    end

    task automatic start_run(input logic [31:0] base, input logic desc, input logic swap);
        @(posedge clk); #1;
        t0 = cyc;
        start_i = 1'b1; base_addr_i = base; desc_order_i = desc; byte_swap_i = swap;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (!busy_o) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: engine still busy, required idle", name);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [127:0] blk_std;
    logic [31:0]  exp_a[4];
    logic [31:0]  exp_d[4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        blk_std = 128'h33333333_22222222_11111111_00000000;
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_busy", 64'(busy_o), 0);
        check("rst_req", 64'(mem_req_o), 0);
        check("rst_halt", 64'(halt_en_o), 0);
        check("rst_addr", 64'(mem_addr_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1. basic ascending
        blk_data_i = blk_std;
        clear_log();
        start_run(32'h1000_0000, 1'b0, 1'b0);
        wait_idle("t1");
        exp_a = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};
        exp_d = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        check("t1_nwrites", 64'(log_q.size()), 4);
        for (int j = 0; j < 4 && j < log_q.size(); j++) begin
            check("t1_addr", 64'(log_q[j].a), 64'(exp_a[j]));
            check("t1_data", 64'(log_q[j].d), 64'(exp_d[j]));
            check("t1_cycle", 64'(log_c[j]), 64'(j + 1));
        end
        check("t1_done_cycle", 64'(done_rel), 5);
        check("t1_halt_cycles", 64'(halt_cnt), 5);

        // 2. descending + byte swap
        blk_data_i = 128'h33333333_22222222_11111111_03020100;
        clear_log();
        start_run(32'h1000_0000, 1'b1, 1'b1);
        wait_idle("t2");
        check("t2_nwrites", 64'(log_q.size()), 4);
        if (log_q.size() == 4) begin
            check("t2_first_addr", 64'(log_q[0].a), 64'h1000_000C);
            check("t2_first_data", 64'(log_q[0].d), 64'h3333_3333);
            check("t2_second_addr", 64'(log_q[1].a), 64'h1000_0008);
            check("t2_last_addr", 64'(log_q[3].a), 64'h1000_0000);
            check("t2_last_data", 64'(log_q[3].d), 64'h0001_0203);
        end

        // 3. stall on second word, block changed mid-run
        blk_data_i = blk_std;
        gmode = 2; glo = 2; ghi = 4;
        clear_log();
        start_run(32'h1000_0000, 1'b0, 1'b0);
        @(posedge clk); #1 blk_data_i = {4{32'hDEAD_BEEF}};
        wait_idle("t3");
        gmode = 0;
        check("t3_hold_cycles", 64'(a4_cnt), 4);
        check("t3_done_cycle", 64'(done_rel), 8);
        check("t3_nwrites", 64'(log_q.size()), 4);
        for (int j = 0; j < 4 && j < log_q.size(); j++) begin
            check("t3_data", 64'(log_q[j].d), 64'(exp_d[j]));
        end
        if (log_c.size() == 4) check("t3_grant2_cycle", 64'(log_c[1]), 5);

        // 4. misaligned start, then aligned restart
        blk_data_i = blk_std;
        clear_log();
        start_run(32'h1000_0002, 1'b0, 1'b0);
        wait_idle("t4");
        check("t4_err_cycle", 64'(err_rel), 1);
        check("t4_req_count", 64'(req_cnt), 0);
        check("t4_halt_count", 64'(halt_cnt), 0);
        clear_log();
        start_run(32'h1000_0000, 1'b0, 1'b0);
        wait_idle("t4b");
        check("t4_restart_nwrites", 64'(log_q.size()), 4);

        // 5. address wrap, start pulsed mid-run
        clear_log();
        start_run(32'hFFFF_FFF8, 1'b0, 1'b0);
        start_i = 1'b1; base_addr_i = 32'h2000_0000;
        @(posedge clk); #1 start_i = 1'b0;
        wait_idle("t5");
        repeat (3) @(posedge clk);
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        check("t5_nwrites", 64'(log_q.size()), 4);
        check("t5_req_count", 64'(req_cnt), 4);
        for (int j = 0; j < 4 && j < log_q.size(); j++) begin
            check("t5_addr", 64'(log_q[j].a), 64'(exp_a[j]));
        end

        // 6. reset mid-run
        clear_log();
        start_run(32'h1000_0000, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_req", 64'(mem_req_o), 0);
        check("t6_busy", 64'(busy_o), 0);
        check("t6_halt", 64'(halt_en_o), 0);
        check("t6_done", 64'(done_o), 0);
        check("t6_be", 64'(mem_be_o), 0);
        check("t6_wdata", 64'(mem_wdata_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 6b. 256-bit block: 8 writes, done in cycle 9
        for (int k = 0; k < 8; k++) blk2[k*32 +: 32] = 32'hA0A0_0000 + 32'(k);
        @(posedge clk); #1;
        t0b = cyc; start2 = 1'b1; base2 = 32'h4000_0000;
        @(posedge clk); #1 start2 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t6b_nwrites", 64'(log2_q.size()), 8);
        check("t6b_done_cycle", 64'(done2_rel), 9);
        for (int k = 0; k < 8 && k < log2_q.size(); k++) begin
            check("t6b_addr", 64'(log2_q[k].a), 64'(32'h4000_0000 + 32'(4 * k)));
            check("t6b_data", 64'(log2_q[k].d), 64'(32'hA0A0_0000 + 32'(k)));
            check("t6b_cycle", 64'(log2_c[k]), 64'(k + 1));
        end

        // Randomized runs against the model
        gmode = 1;
        for (int r = 0; r < 40; r++) begin
            logic [31:0] b;
            blk_data_i = {$urandom, $urandom, $urandom, $urandom};
            b = $urandom;
            if (($urandom % 4) != 0) b[1:0] = 2'b00;
            start_run(b, 1'($urandom), 1'($urandom));
            for (int i = 0; i < 300; i++) begin
                if (!busy_o) break;
                start_i = (($urandom % 5) == 0);
                base_addr_i = $urandom;
                if (($urandom % 3) == 0) blk_data_i = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
            end
            start_i = 1'b0;
            @(posedge clk); #1;
        end
        gmode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_blk_wb.md
Name: riscv_blk_wb

Overview:
Parametrised write-back engine that stores a wide result block, such as an AES ciphertext, to data memory as a sequence of word writes while holding the core halted. It is the successor to the fixed 128-bit/4-word AES write-back.
- Generalised in block and word width.
- Snapshots the block at start.
- Uses a req/gnt memory handshake and tolerates stalls.
- Supports ascending/descending word order and per-word byte swap.
- Flags misaligned base addresses.

It sits between accelerator result registers and the core's LSU/data-memory arbiter.

Parameters:
- BLK_W, 128: block width in bits; must be a multiple of WORD_W.
- WORD_W, 32: memory word width in bits; a multiple of 8.
- ADDR_W, 32: byte address width.
- Derived (localparam, not overridable): NUM_W = BLK_W/WORD_W; WB = WORD_W/8; CNT_W = $clog2(NUM_W), minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- base_addr_i  in  ADDR_W  byte address of block word 0.
- blk_data_i  in  BLK_W  result block; word k = bits [k*WORD_W +: WORD_W].
- desc_order_i  in  1  0: write words 0..N-1; 1: write words N-1..0.
- byte_swap_i  in  1  reverse byte order within each written word.
- busy_o  out  1  engine not in IDLE.
- halt_en_o  out  1  core halt request.
- done_o  out  1  one-cycle pulse when the last write is granted plus one cycle.
- err_o  out  1  one-cycle pulse on a misaligned start.
- mem_req_o  out  1  write request; held until granted.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  ADDR_W  write byte address.
- mem_wdata_o  out  WORD_W  write data.
- mem_be_o  out  WB  byte enables; all ones whenever mem_req_o=1, else 0.

Behaviour:
Clock and reset:
- One clock, clk. Reset rst_n is synchronous and active-low.
- In reset all outputs are 0; state=IDLE, idx=0, snapshot registers=0.
- All outputs are registered.

Start and snapshot:
- A start is accepted in IDLE only.
- On acceptance, capture blk_data_i, base_addr_i, desc_order_i and byte_swap_i.
- Input changes after acceptance have no effect.

States: IDLE, WRITE, DONE, ERR.
- IDLE, start_i=1, base_addr_i[log2(WB)-1:0]==0:
  - Next state WRITE.
  - Next cycle: mem_req_o=1, halt_en_o=1, busy_o=1.
  - First word index k0 = 0 (ascending) or NUM_W-1 (descending).
- IDLE, start_i=1, misaligned: next state ERR.
- ERR: err_o=1 for exactly one cycle, busy_o=1, halt_en_o=0, no request issued; then IDLE.
- WRITE:
  - Outputs:
    - mem_addr_o = base + k*WB, computed modulo 2^ADDR_W (wrap allowed, no error).
    - mem_wdata_o = word k, byte-reversed if the swap bit was captured.
  - Request stability: while mem_gnt_i=0, mem_req_o, mem_addr_o and mem_wdata_o hold stable.
  - On a grant cycle (mem_req_o & mem_gnt_i):
    - If this is the last word: next state DONE, mem_req_o=0.
    - Otherwise step to the next k; a new request is presented the very next cycle, so there is no bubble.
- DONE:
  - done_o=1 and halt_en_o=1 for one cycle; mem_req_o=0.
  - Then IDLE, with halt_en_o=0 and busy_o=0.
- start_i asserted while busy is ignored; it is not queued.

Latency, with start in cycle 0 and gnt tied high:
- Requests in cycles 1..NUM_W.
- done_o in cycle NUM_W+1.
- halt_en_o high in cycles 1..NUM_W+1.
- Each cycle of gnt low adds one cycle.

Edge cases:
- Reset mid-operation: the next edge forces IDLE and all outputs to 0. The abandoned request is the system's responsibility.
- NUM_W=1: a single write, then DONE.
- mem_gnt_i is ignored when mem_req_o=0.

Decomposition:
- Package riscv_blk_wb_pkg:
  - state enum blk_wb_state_e {IDLE, WRITE, DONE, ERR}.
  - Function bswap_word for a parametrised WORD_W.
  - Function is_aligned(addr, WB).
- Optional sub-module riscv_blk_wb_sel: combinational word select plus byte swap (snapshot, k, swap -> word). Keeps the FSM file readable.

Test Plan:
Common stimulus: blk = 128'h33333333_22222222_11111111_00000000, default parameters.
1. Basic ascending: start, base=0x1000_0000, gnt=1.
   - Writes (0x1000_0000, 0x00000000), (0x1000_0004, 0x11111111), (0x1000_0008, 0x22222222), (0x1000_000C, 0x33333333) in cycles 1-4.
   - done_o in cycle 5; halt_en_o high in cycles 1-5; mem_be_o=4'hF.
2. Descending + swap, same blk with word0=0x03020100:
   - First write is (0x1000_000C, 0x33333333).
   - Word0 is written last as 0x00010203 at 0x1000_0000.
3. Stall: gnt low for 3 cycles on the second word.
   - addr 0x1000_0004 and data held for 4 cycles.
   - done_o in cycle 8; blk_data_i changed mid-run does not alter the written data.
4. Misaligned start (base=0x1000_0002):
   - err_o pulse in cycle 1; no mem_req_o; halt_en_o stays 0; a fresh aligned start is then accepted.
5. Wrap and mid-run start: base=0xFFFF_FFF8.
   - Addresses F8, FC, 0x0000_0000, 0x0000_0004.
   - start_i pulsed in cycle 2 is ignored; exactly 4 writes occur.
6. Reset mid-run: rst_n low in cycle 2.
   - All outputs 0 at the next edge.
   - With BLK_W=256, a re-run after reset produces 8 writes with done_o in cycle 9.
